dac_spi_writer: RTL

Serial writer for the two-channel 12-bit SPI DAC module on a J-port header. It is the output-side counterpart of the potentiometer ADC reader. It accepts one pair of 12-bit samples through a valid/ready handshake and shifts each sample out as a 16-bit SPI frame. The game logic in the top level uses it to drive paddle-hit and score tones.

---
 rtl/dac_spi_writer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dac_spi_writer.sv
// dac_spi_writer: serial writer for a two-channel 12-bit SPI DAC.
// Takes one pair of 12-bit samples per valid/ready handshake and shifts each
// one out MSB first as a 16-bit frame {2 don't-care, PD1=0, PD0=0, data}.
// Optional feature macro: DAC_DUAL_CHANNEL_EN
//   defined   -> sampleB has its own shift register driving dac_dinb
//   undefined -> sampleB is ignored and dac_dinb mirrors dac_dina
//
// Handshake: a sample pair is accepted at a rising edge where sample_valid
// and sample_ready are both 1. sample_ready is registered, is high only in
// IDLE, and valid without ready is simply ignored (nothing is queued).
module dac_spi_writer #(
  parameter int CLK_DIV    = 2,  // SCLK half-period in sys_clk cycles, 1..255
  parameter int GAP_CYCLES = 2   // minimum SYNC-high time between frames, 1..255
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic [11:0] sampleA,
  input  logic [11:0] sampleB,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        busy,
  output logic        done,
  output logic        dac_sync,
  output logic        dac_sclk,
  output logic        dac_dina,
  output logic        dac_dinb,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [4:0] BIT_LAST = 5'd16;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  gap_q, gap_d;
  logic [4:0]  bit_q, bit_d;      // SCLK falling edges seen so far, 0..16
  logic        sclk_q, sclk_d;
  logic        sync_q, sync_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic [15:0] sha_q, sha_d;

`ifdef DAC_DUAL_CHANNEL_EN
  logic [15:0] shb_q, shb_d;
`else
  logic        unused_sample_b;
  assign unused_sample_b = ^sampleB;
`endif

  // Next-state and next-output logic for the IDLE/SHIFT/GAP sequencer
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    sync_d  = sync_q;
    done_d  = 1'b0;
    sha_d   = sha_q;
`ifdef DAC_DUAL_CHANNEL_EN
    shb_d   = shb_q;
`endif
    case (state_q)
      IDLE: begin
        if (sample_valid && ready_q) begin
          state_d = SHIFT;
          sha_d   = {4'b0000, sampleA};
`ifdef DAC_DUAL_CHANNEL_EN
          shb_d   = {4'b0000, sampleB};
`endif
          sync_d  = 1'b0;
          sclk_d  = 1'b1;
          div_d   = 8'd0;
          bit_d   = 5'd0;
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          if (sclk_q) begin
            // Falling edge: the DAC samples DIN here.
            sclk_d = 1'b0;
            bit_d  = bit_q + 5'd1;
          end else if (bit_q == BIT_LAST) begin
            // The rise after the 16th fall closes the frame instead of shifting.
            sclk_d  = 1'b1;
            sync_d  = 1'b1;
            done_d  = 1'b1;
            state_d = GAP;
            gap_d   = 8'd0;
          end else begin
            // Rising edge: advance DIN to the next bit.
            sclk_d = 1'b1;
            sha_d  = {sha_q[14:0], 1'b0};
`ifdef DAC_DUAL_CHANNEL_EN
            shb_d  = {shb_q[14:0], 1'b0};
`endif
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers; reset may land mid-frame and aborts it
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      gap_q   <= 8'd0;
      bit_q   <= 5'd0;
      sclk_q  <= 1'b1;
      sync_q  <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      sha_q   <= 16'd0;
`ifdef DAC_DUAL_CHANNEL_EN
      shb_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      sync_q  <= sync_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      sha_q   <= sha_d;
`ifdef DAC_DUAL_CHANNEL_EN
      shb_q   <= shb_d;
`endif
    end
  end

  assign sample_ready = ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign dac_sync     = sync_q;
  assign dac_sclk     = sclk_q;
  assign dac_dina     = sha_q[15];
`ifdef DAC_DUAL_CHANNEL_EN
  assign dac_dinb     = shb_q[15];
`else
  assign dac_dinb     = sha_q[15];
`endif
  assign dbg_state_o  = state_q;

endmodule
